// File: rtl/ripple_sub_pipe_pkg.sv
// ripple_sub_pipe_pkg: width constants shared by the pipelined ripple adder and subtractor.
package ripple_sub_pipe_pkg;
   localparam int WIDTH_DEF = 8;
   localparam int MSB_DEF   = WIDTH_DEF - 1;
endpackage

// File: rtl/ripple_sub_pipe_full_adder.sv
// full_adder: single-bit full adder cell used to build the ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ripple_sub_pipe.sv
// ripple_sub_pipe: two-stage valid/ready unsigned subtractor D = A - B with borrow.
// Define RIPPLE_SUB_OVERFLOW_EN to add the registered signed-overflow output V.
module ripple_sub_pipe
   import ripple_sub_pipe_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
`ifdef RIPPLE_SUB_OVERFLOW_EN
   output logic             V,
`endif
   output logic             Bout
);
   localparam int MSB = WIDTH - 1;
   logic             s1_valid;
   logic [WIDTH-1:0] a_reg, b_reg, diff;
   logic [WIDTH:0]   c;
   logic             adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = !s1_valid || adv;
   // A + ~B + 1: inverted subtrahend with the chain's carry-in forced high
   assign c[0] = 1'b1;
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a   (a_reg[i]),
         .b   (~b_reg[i]),
         .cin (c[i]),
         .s   (diff[i]),
         .cout(c[i+1])
      );
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
      end else if (in_valid && in_ready) begin
         s1_valid  <= 1'b1;
         a_reg     <= A;
         b_reg     <= B;
      end else if (adv) begin
         s1_valid  <= 1'b0;
      end
   end
   // Result registers only load real data so they hold their last value when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         D         <= '0;
         Bout      <= 1'b0;
`ifdef RIPPLE_SUB_OVERFLOW_EN
         V         <= 1'b0;
`endif
      end else if (adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            D    <= diff;
            Bout <= ~c[WIDTH];
`ifdef RIPPLE_SUB_OVERFLOW_EN
            V    <= (a_reg[MSB] != b_reg[MSB]) && (diff[MSB] != a_reg[MSB]);
`endif
         end
      end
   end
endmodule

// File: tb/tb_ripple_sub_pipe.sv
// tb_ripple_sub_pipe: scoreboard bench for ripple_sub_pipe (honours RIPPLE_SUB_OVERFLOW_EN).
module tb_ripple_sub_pipe;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready, Bout;
   logic [W-1:0] A, B, D;
`ifdef RIPPLE_SUB_OVERFLOW_EN
   logic         V;
`endif
   typedef struct packed {
      logic         v;
      logic         bout;
      logic [W-1:0] d;
   } exp_t;
   exp_t q[$];
   int   n_chk = 0, n_err = 0, stalls = 0;

   ripple_sub_pipe #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .D        (D),
`ifdef RIPPLE_SUB_OVERFLOW_EN
      .V        (V),
`endif
      .Bout     (Bout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.d    = a - b;
      e.bout = a < b;
      e.v    = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
      return e;
   endfunction

   // Called just after a rising edge; returns just after the edge that accepts the pair.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int i;
      in_valid = 1'b1;
      A = a;
      B = b;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) break;
         if (i == 0) stalls++;
      end
      if (i == 200) begin
         check("accept_timeout", 0, 1);
      end else begin
         q.push_back(model(a, b));
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
      #1 check("drain_left", q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("d", D, e.d);
            check("bout", Bout, e.bout);
`ifdef RIPPLE_SUB_OVERFLOW_EN
            check("v", V, e.v);
`endif
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] ta[5] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h80};
      logic [W-1:0] tb[5] = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h01};
      logic [W-1:0] d0;
      logic         b0;
      rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_d", D, 0);
      check("rst_bout", Bout, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      send(8'd5, 8'd3);
      @(posedge clk); #1;
      check("lat_valid", out_valid, 1);
      check("lat_d", D, 8'h02);
      check("lat_bout", Bout, 0);
      send(8'd3, 8'd5);
      @(posedge clk); #1;
      check("neg_d", D, 8'hFE);
      check("neg_bout", Bout, 1);
      for (int i = 0; i < 5; i++) send(ta[i], tb[i]);
      @(posedge clk); #1;
      check("b128_d", D, 8'h7F);
`ifdef RIPPLE_SUB_OVERFLOW_EN
      check("b128_v", V, 1);
`endif
      drain();
      stalls = 0;
      for (int i = 0; i < 50; i++) send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      check("stream_stalls", stalls, 0);
      drain();
      out_ready = 1'b0;
      send(8'd200, 8'd100);
      send(8'd10, 8'd20);
      d0 = D;
      b0 = Bout;
      fork
         send(8'd77, 8'd7);
         begin
            repeat (4) begin
               @(negedge clk);
               check("bp_in_ready", in_ready, 0);
               check("bp_out_valid", out_valid, 1);
               check("bp_d_hold", D, d0);
               check("bp_bout_hold", Bout, b0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      out_ready = 1'b0;
      send(8'd9, 8'd4);
      send(8'd1, 8'd2);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_d", D, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
